// File: rtl/ysyx_lsu.sv
// ysyx_lsu: load/store unit between execute and writeback.
// Each access is checked for legality, issued to memory with byte-lane
// steering, and completed with an extended load result or an error.
module ysyx_lsu #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_rd_sel,
   input  logic [1:0]  req_wr_sel,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_e;

   state_e        state_q, state_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [2:0]    rd_sel_q, rd_sel_d;
   logic [1:0]    wr_sel_q, wr_sel_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;

   logic          req_none;
   logic          req_bad;
   logic          is_half_in;
   logic          is_word_in;
   logic          timeout_hit;
   logic [7:0]    byte_lane;
   logic [15:0]   half_lane;
   logic [31:0]   load_data;
   logic [31:0]   store_data;
   logic [3:0]    store_strb;

   // Classify the incoming request: no-op, illegal/misaligned, or a real access.
   always_comb begin
      is_half_in = (req_rd_sel == 3'b011) || (req_rd_sel == 3'b100) || (req_wr_sel == 2'b10);
      is_word_in = (req_rd_sel == 3'b101) || (req_wr_sel == 2'b11);
      req_none   = (req_rd_sel == 3'b000) && (req_wr_sel == 2'b00);
      req_bad    = ((req_rd_sel != 3'b000) && (req_wr_sel != 2'b00))
                || (req_rd_sel > 3'b101)
                || (is_half_in && req_addr[0])
                || (is_word_in && (req_addr[1:0] != 2'b00));
   end

   // Pick the addressed lane out of the returned word and extend it by load type.
   always_comb begin
      case (addr_q[1:0])
         2'b00:   byte_lane = mem_rdata[7:0];
         2'b01:   byte_lane = mem_rdata[15:8];
         2'b10:   byte_lane = mem_rdata[23:16];
         default: byte_lane = mem_rdata[31:24];
      endcase
      half_lane = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (rd_sel_q)
         3'b001:  load_data = {{24{byte_lane[7]}}, byte_lane};
         3'b010:  load_data = {24'h000000, byte_lane};
         3'b011:  load_data = {{16{half_lane[15]}}, half_lane};
         3'b100:  load_data = {16'h0000, half_lane};
         3'b101:  load_data = mem_rdata;
         default: load_data = 32'h0;
      endcase
   end

   // Replicate store data across lanes and enable only the addressed bytes.
   always_comb begin
      case (wr_sel_q)
         2'b01: begin
            store_data = {4{wdata_q[7:0]}};
            store_strb = 4'b0001 << addr_q[1:0];
         end
         2'b10: begin
            store_data = {2{wdata_q[15:0]}};
            store_strb = addr_q[1] ? 4'b1100 : 4'b0011;
         end
         2'b11: begin
            store_data = wdata_q;
            store_strb = 4'b1111;
         end
         default: begin
            store_data = 32'h0;
            store_strb = 4'b0000;
         end
      endcase
   end

   // Next-state and output logic; the counter stops before it could wrap because
   // reaching the limit always leaves ISSUE/WAIT.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rd_sel_d    = rd_sel_q;
      wr_sel_d    = wr_sel_q;
      cnt_d       = cnt_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = 32'h0;
      mem_wdata   = 32'h0;
      mem_wstrb   = 4'b0000;
      timeout_hit = (cnt_q >= CW'(TIMEOUT - 1));

      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               rd_sel_d = req_rd_sel;
               wr_sel_d = req_wr_sel;
               if (req_none) begin
                  state_d = S_DONE;
                  rdata_d = 32'h0;
                  err_d   = 1'b0;
               end else if (req_bad) begin
                  state_d = S_DONE;
                  rdata_d = 32'h0;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_ISSUE;
                  cnt_d   = '0;
               end
            end
         end
         S_ISSUE: begin
            mem_req   = 1'b1;
            mem_we    = (wr_sel_q != 2'b00);
            mem_addr  = {addr_q[31:2], 2'b00};
            mem_wdata = store_data;
            mem_wstrb = store_strb;
            if (timeout_hit) begin
               state_d = S_DONE;
               rdata_d = 32'h0;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (mem_gnt) begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               state_d = S_DONE;
               rdata_d = (wr_sel_q != 2'b00) ? 32'h0 : load_data;
               err_d   = 1'b0;
            end else if (timeout_hit) begin
               state_d = S_DONE;
               rdata_d = 32'h0;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   // State and datapath registers; reset abandons any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         rd_sel_q <= 3'b000;
         wr_sel_q <= 2'b00;
         cnt_q    <= '0;
         rdata_q  <= 32'h0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rd_sel_q <= rd_sel_d;
         wr_sel_q <= wr_sel_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_ysyx_lsu.sv
// tb_ysyx_lsu: directed vectors plus hand-written stall, timeout and reset sequences.
module tb_ysyx_lsu;

   localparam int TO = 8;
   localparam int NV = 18;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_rd_sel;
   logic [1:0]  req_wr_sel;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int checks_total  = 0;
   int checks_passed = 0;

   typedef struct packed {
      logic [2:0]  rd_sel;
      logic [1:0]  wr_sel;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mrdata;
      logic        exp_issue;
      logic        exp_we;
      logic [3:0]  exp_wstrb;
      logic [31:0] exp_maddr;
      logic [31:0] exp_mwdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [NV];

   ysyx_lsu #(.TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_rd_sel (req_rd_sel),
      .req_wr_sel (req_wr_sel),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wstrb  (mem_wstrb),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Absolute time bound so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks_total++;
      if (actual !== expected)
         $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
      else
         checks_passed++;
   endtask

   task automatic checkMem(input string tag, input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
      checkOutput({tag, " mem_req"},   {31'h0, mem_req}, {31'h0, req});
      checkOutput({tag, " mem_we"},    {31'h0, mem_we},  {31'h0, we});
      checkOutput({tag, " mem_addr"},  mem_addr,  addr);
      checkOutput({tag, " mem_wdata"}, mem_wdata, wdata);
      checkOutput({tag, " mem_wstrb"}, {28'h0, mem_wstrb}, {28'h0, wstrb});
   endtask

   task automatic checkResp(input string tag, input logic valid, input logic [31:0] rdata, input logic err);
      checkOutput({tag, " resp_valid"}, {31'h0, resp_valid}, {31'h0, valid});
      checkOutput({tag, " resp_rdata"}, resp_rdata, rdata);
      checkOutput({tag, " resp_err"},   {31'h0, resp_err},   {31'h0, err});
   endtask

   // Present a request at the falling edge so it is accepted at the next rising edge.
   task automatic driveReq(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge clk);
      req_valid  = 1'b1;
      req_rd_sel = rd;
      req_wr_sel = wr;
      req_addr   = addr;
      req_wdata  = wdata;
      #1;
      checkOutput("accept req_ready", {31'h0, req_ready}, 32'h1);
   endtask

   // Withdraw the request and scramble its fields so only latched values matter.
   task automatic dropReq();
      req_valid  = 1'b0;
      req_rd_sel = 3'b111;
      req_wr_sel = 2'b11;
      req_addr   = 32'hFFFF_FFFF;
      req_wdata  = 32'h5555_5555;
   endtask

   task automatic applyStimulus(input int i);
      string tag;
      vec_t  v;
      v   = vecs[i];
      tag = $sformatf("v%0d", i);
      resp_ready = 1'b1;
      driveReq(v.rd_sel, v.wr_sel, v.addr, v.wdata);
      @(negedge clk);
      dropReq();
      if (v.exp_issue) begin
         mem_gnt = 1'b1;
         #1;
         checkMem({tag, " issue"}, 1'b1, v.exp_we, v.exp_maddr, v.exp_mwdata, v.exp_wstrb);
         checkOutput({tag, " issue req_ready"}, {31'h0, req_ready}, 32'h0);
         @(negedge clk);
         mem_gnt    = 1'b0;
         mem_rvalid = 1'b1;
         mem_rdata  = v.mrdata;
         #1;
         checkMem({tag, " wait"}, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
         checkOutput({tag, " wait resp_valid"}, {31'h0, resp_valid}, 32'h0);
         @(negedge clk);
         mem_rvalid = 1'b0;
         mem_rdata  = 32'h0;
      end
      #1;
      checkOutput({tag, " done mem_req"}, {31'h0, mem_req}, 32'h0);
      checkResp({tag, " done"}, 1'b1, v.exp_rdata, v.exp_err);
      @(negedge clk);
      #1;
      checkOutput({tag, " idle req_ready"}, {31'h0, req_ready}, 32'h1);
      checkOutput({tag, " idle resp_valid"}, {31'h0, resp_valid}, 32'h0);
   endtask

   initial begin
      //          rd      wr     addr          wdata         mrdata        iss we  strb     maddr         mwdata        rdata         err
      vecs[0]  = '{3'b101, 2'b00, 32'h80000004, 32'h00000000, 32'h12345678, 1'b1, 1'b0, 4'b0000, 32'h80000004, 32'h00000000, 32'h12345678, 1'b0};
      vecs[1]  = '{3'b001, 2'b00, 32'h80000003, 32'h00000000, 32'h80FF0011, 1'b1, 1'b0, 4'b0000, 32'h80000000, 32'h00000000, 32'hFFFFFF80, 1'b0};
      vecs[2]  = '{3'b010, 2'b00, 32'h80000003, 32'h00000000, 32'h80FF0011, 1'b1, 1'b0, 4'b0000, 32'h80000000, 32'h00000000, 32'h00000080, 1'b0};
      vecs[3]  = '{3'b011, 2'b00, 32'h80000002, 32'h00000000, 32'h80FF0011, 1'b1, 1'b0, 4'b0000, 32'h80000000, 32'h00000000, 32'hFFFF80FF, 1'b0};
      vecs[4]  = '{3'b100, 2'b00, 32'h80000000, 32'h00000000, 32'h1234F00D, 1'b1, 1'b0, 4'b0000, 32'h80000000, 32'h00000000, 32'h0000F00D, 1'b0};
      vecs[5]  = '{3'b001, 2'b00, 32'h80000001, 32'h00000000, 32'h1234F00D, 1'b1, 1'b0, 4'b0000, 32'h80000000, 32'h00000000, 32'hFFFFFFF0, 1'b0};
      vecs[6]  = '{3'b010, 2'b00, 32'h80000000, 32'h00000000, 32'h80FF0011, 1'b1, 1'b0, 4'b0000, 32'h80000000, 32'h00000000, 32'h00000011, 1'b0};
      vecs[7]  = '{3'b000, 2'b10, 32'h80000002, 32'h0000ABCD, 32'hDEADBEEF, 1'b1, 1'b1, 4'b1100, 32'h80000000, 32'hABCDABCD, 32'h00000000, 1'b0};
      vecs[8]  = '{3'b000, 2'b01, 32'h10000001, 32'h000000A5, 32'hDEADBEEF, 1'b1, 1'b1, 4'b0010, 32'h10000000, 32'hA5A5A5A5, 32'h00000000, 1'b0};
      vecs[9]  = '{3'b000, 2'b11, 32'h10000008, 32'hCAFEF00D, 32'hDEADBEEF, 1'b1, 1'b1, 4'b1111, 32'h10000008, 32'hCAFEF00D, 32'h00000000, 1'b0};
      vecs[10] = '{3'b000, 2'b10, 32'h10000000, 32'h12345678, 32'h00000000, 1'b1, 1'b1, 4'b0011, 32'h10000000, 32'h56785678, 32'h00000000, 1'b0};
      vecs[11] = '{3'b000, 2'b01, 32'h10000003, 32'h0000005A, 32'h00000000, 1'b1, 1'b1, 4'b1000, 32'h10000000, 32'h5A5A5A5A, 32'h00000000, 1'b0};
      vecs[12] = '{3'b101, 2'b00, 32'h80000002, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 4'b0000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1};
      vecs[13] = '{3'b000, 2'b00, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 4'b0000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
      vecs[14] = '{3'b101, 2'b11, 32'h80000000, 32'h11111111, 32'h00000000, 1'b0, 1'b0, 4'b0000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1};
      vecs[15] = '{3'b110, 2'b00, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 4'b0000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1};
      vecs[16] = '{3'b011, 2'b00, 32'h80000001, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 4'b0000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1};
      vecs[17] = '{3'b000, 2'b11, 32'h80000002, 32'h22222222, 32'h00000000, 1'b0, 1'b0, 4'b0000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1};

      rst        = 1'b1;
      req_valid  = 1'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      req_rd_sel = 3'b000;
      req_wr_sel = 2'b00;
      resp_ready = 1'b1;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;

      // Reset state.
      @(negedge clk);
      #1;
      checkOutput("reset req_ready", {31'h0, req_ready}, 32'h1);
      checkMem("reset", 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
      checkResp("reset", 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) applyStimulus(i);

      // Store with grant withheld three cycles; stray rvalid during ISSUE must be ignored.
      resp_ready = 1'b0;
      driveReq(3'b000, 2'b01, 32'h80000013, 32'h000000C3);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         dropReq();
         mem_gnt    = (k == 3);
         mem_rvalid = 1'b1;
         mem_rdata  = 32'hFFFF_FFFF;
         #1;
         checkMem($sformatf("stall%0d", k), 1'b1, 1'b1, 32'h80000010, 32'hC3C3C3C3, 4'b1000);
         checkOutput($sformatf("stall%0d resp_valid", k), {31'h0, resp_valid}, 32'h0);
      end
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      #1;
      checkOutput("stall wait resp_valid", {31'h0, resp_valid}, 32'h0);
      @(negedge clk);
      mem_rvalid = 1'b1;
      @(negedge clk);
      mem_rvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k == 2) resp_ready = 1'b1;
         #1;
         checkResp($sformatf("stall hold%0d", k), 1'b1, 32'h0, 1'b0);
         @(negedge clk);
      end
      #1;
      checkOutput("stall after resp_valid", {31'h0, resp_valid}, 32'h0);

      // Load whose result must stay stable while writeback stalls.
      resp_ready = 1'b0;
      driveReq(3'b101, 2'b00, 32'h80000010, 32'h0);
      @(negedge clk);
      dropReq();
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h0BADF00D;
      @(negedge clk);
      mem_rvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         mem_rdata = 32'h1111_1111 * (k + 1);
         if (k == 2) resp_ready = 1'b1;
         #1;
         checkResp($sformatf("hold%0d", k), 1'b1, 32'h0BADF00D, 1'b0);
         @(negedge clk);
      end

      // Reset during WAIT abandons the access; a late rvalid is ignored.
      driveReq(3'b101, 2'b00, 32'h80000040, 32'h0);
      @(negedge clk);
      dropReq();
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      rst     = 1'b1;
      #1;
      checkOutput("rst req_ready", {31'h0, req_ready}, 32'h1);
      checkMem("rst", 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
      checkResp("rst", 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h7777_7777;
      #1;
      checkOutput("late rvalid resp_valid", {31'h0, resp_valid}, 32'h0);
      @(negedge clk);
      mem_rvalid = 1'b0;
      #1;
      checkResp("after late", 1'b0, 32'h0, 1'b0);
      checkOutput("after late req_ready", {31'h0, req_ready}, 32'h1);

      // Timeout in ISSUE: grant never comes.
      driveReq(3'b101, 2'b00, 32'h80000020, 32'h0);
      for (int k = 0; k < TO; k++) begin
         @(negedge clk);
         dropReq();
         #1;
         checkOutput($sformatf("to_issue%0d mem_req", k), {31'h0, mem_req}, 32'h1);
         checkOutput($sformatf("to_issue%0d resp_valid", k), {31'h0, resp_valid}, 32'h0);
      end
      @(negedge clk);
      #1;
      checkOutput("to_issue end mem_req", {31'h0, mem_req}, 32'h0);
      checkResp("to_issue end", 1'b1, 32'h0, 1'b1);

      // Timeout in WAIT: granted at once but rvalid never comes.
      driveReq(3'b101, 2'b00, 32'h80000024, 32'h0);
      @(negedge clk);
      dropReq();
      mem_gnt = 1'b1;
      #1;
      checkOutput("to_wait issue mem_req", {31'h0, mem_req}, 32'h1);
      for (int k = 1; k < TO; k++) begin
         @(negedge clk);
         mem_gnt = 1'b0;
         #1;
         checkOutput($sformatf("to_wait%0d resp_valid", k), {31'h0, resp_valid}, 32'h0);
      end
      @(negedge clk);
      #1;
      checkResp("to_wait end", 1'b1, 32'h0, 1'b1);
      @(negedge clk);
      #1;
      checkOutput("final req_ready", {31'h0, req_ready}, 32'h1);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
